i2s_rx_slave: RTL and testbench
===============================

Name: i2s_rx_slave

Overview:
- I2S slave receiver for the codec ADC path. Deserializes the stereo serial stream into parallel 16-bit left/right samples for the denoise datapath.
- Bit clock and word select are mastered by the codec. Sits at the front of the audio chain; mirror of the transmit slave at the back.
- Outputs are held stable between commits, so downstream logic may sample them at any time after a valid strobe.

Parameters:
- DATA_W, 16, captured bits per channel word (MSB first); serial bits beyond DATA_W in a half-frame are ignored.
- SLOT_MAX, 32, maximum bclk cycles per half-frame; width of the internal slot counter is clog2(SLOT_MAX+1).

Ports:
- bclk  in  1  codec bit clock; the only clock; all logic on posedge bclk.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge bclk).
- lrck  in  1  word select from codec; 0 = left channel, 1 = right channel.
- sdata  in  1  serial data from codec ADC; changes on negedge bclk.
- l_data  out  DATA_W  last committed left word, held.
- r_data  out  DATA_W  last committed right word, held.
- l_valid  out  1  one-cycle pulse when l_data updates.
- r_valid  out  1  one-cycle pulse when r_data updates.
- pair_valid  out  1  one-cycle pulse when a right word commits and a left word committed in the same frame.
- err_short  out  1  sticky; a half-frame ended before DATA_W bits were captured.

Behaviour:
- Reset (rst==0): l_data=r_data=0; l_valid=r_valid=pair_valid=0; err_short=0; shift register=0; bit count=0; lrck_d=0; synced=0; left_seen=0.
- lrck_d registers lrck each posedge. An edge is lrck!=lrck_d at a posedge.
- Data samples sdata at posedge bclk. I2S one-bit delay applies: the MSB is sampled on the posedge after the edge-detect posedge.
- States: UNSYNC, WAIT_MSB, SHIFT, DONE.
  - UNSYNC: entered from reset. Ignores sdata. Goes to WAIT_MSB on the first lrck edge, so a partial first word is never committed.
  - WAIT_MSB: lasts one cycle. Clears the shift register and bit count, latches the channel = lrck_d (new value), then goes to SHIFT.
  - SHIFT: each posedge shifts sdata into the LSB end and increments the bit count. At count==DATA_W, commits and goes to DONE.
  - DONE: ignores sdata until the next lrck edge, then goes to WAIT_MSB.
- Commit:
  - Writes the word to l_data or r_data per the latched channel and pulses l_valid or r_valid on the posedge after the last bit was sampled.
  - Latency: the strobe occurs DATA_W+1 posedges after the edge-detect posedge.
- Short half-frame: an lrck edge while in SHIFT with count<DATA_W:
  - commits the partial word left-aligned (missing LSBs = 0) on that same posedge;
  - sets err_short;
  - goes to WAIT_MSB.
- A slot counter increments every posedge in SHIFT/DONE. At SLOT_MAX with no edge, it returns to UNSYNC (lost lrck) without committing.
- pair_valid:
  - A left commit sets left_seen.
  - A right commit pulses pair_valid in the same cycle as r_valid only if left_seen==1, then clears left_seen.
  - A right commit with left_seen==0 (stream started on right) gives r_valid only.
- Only one valid strobe is asserted per cycle; l_valid and r_valid are never simultaneous.
- err_short clears only on reset.
- Reset mid-word: the partial word is discarded, l_data/r_data go to 0, and the block returns to UNSYNC.

Test Plan:
- Reset with lrck=0 static and sdata toggling -> all outputs 0, no strobes, state stays UNSYNC.
- Standard 32-slot I2S frames, left=0xA5C3, right=0x1234 -> l_valid at edge+17 posedges with l_data=0xA5C3; r_valid and pair_valid together with r_data=0x1234; bits 17–32 of each slot ignored.
- Stream starting mid-right-slot after reset -> no commit until the first full left word; the first right commit after it pulses pair_valid.
- lrck toggles after 10 left bits of 0xFFFF -> l_data=0xFFC0, l_valid pulses at that edge, err_short=1 and remains 1 across later good frames.
- lrck held constant for 40 bclks after sync -> return to UNSYNC, no strobes; resumes correctly on the next edge.
- rst low for one cycle while 8 bits into a right word -> r_data=0, no r_valid, resync on the next edge, then 0x7FFF/0x8000 words captured correctly.

Source files
------------

// File: rtl/i2s_rx_slave.sv
// I2S slave receiver: deserializes the codec ADC stream into held 16-bit left/right words.
// Strobes pulse one cycle per commit; err_short latches any truncated half-frame.
module i2s_rx_slave #(
   parameter int DATA_W   = 16,
   parameter int SLOT_MAX = 32
) (
   input  logic              bclk,
   input  logic              rst,
   input  logic              lrck,
   input  logic              sdata,
   output logic [DATA_W-1:0] l_data,
   output logic [DATA_W-1:0] r_data,
   output logic              l_valid,
   output logic              r_valid,
   output logic              pair_valid,
   output logic              err_short
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int SLOT_W = $clog2(SLOT_MAX + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DATA_W);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_MAX);

   localparam logic [1:0] UNSYNC   = 2'd0;
   localparam logic [1:0] WAIT_MSB = 2'd1;
   localparam logic [1:0] SHIFT    = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   logic [1:0]        state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SLOT_W-1:0] slot_cnt;
   logic              lrck_d;
   logic              synced;
   logic              channel;
   logic              left_seen;
   logic              lr_edge;
   logic              commit;
   logic              short_word;
   logic [DATA_W-1:0] commit_word;

   // lrck_d holds its reset value for the first cycle out of reset, so an lrck
   // already high then is not a real edge; synced masks that false edge.
   assign lr_edge = synced && (lrck != lrck_d);

   // A commit is a full word, or a truncated word left-aligned when lrck moves early.
   always_comb begin
      commit      = 1'b0;
      short_word  = 1'b0;
      commit_word = shreg;
      if (state == SHIFT) begin
         if (bit_cnt == FULL_CNT) begin
            commit = 1'b1;
         end else if (lr_edge) begin
            commit      = 1'b1;
            short_word  = 1'b1;
            commit_word = shreg << (FULL_CNT - bit_cnt);
         end
      end
   end

   always_ff @(posedge bclk) begin
      if (!rst) begin
         state      <= UNSYNC;
         shreg      <= '0;
         bit_cnt    <= '0;
         slot_cnt   <= '0;
         lrck_d     <= 1'b0;
         synced     <= 1'b0;
         channel    <= 1'b0;
         left_seen  <= 1'b0;
         l_data     <= '0;
         r_data     <= '0;
         l_valid    <= 1'b0;
         r_valid    <= 1'b0;
         pair_valid <= 1'b0;
         err_short  <= 1'b0;
      end else begin
         lrck_d     <= lrck;
         synced     <= 1'b1;
         l_valid    <= 1'b0;
         r_valid    <= 1'b0;
         pair_valid <= 1'b0;

         if (commit) begin
            if (!channel) begin
               l_data    <= commit_word;
               l_valid   <= 1'b1;
               left_seen <= 1'b1;
            end else begin
               r_data     <= commit_word;
               r_valid    <= 1'b1;
               pair_valid <= left_seen;
               left_seen  <= 1'b0;
            end
         end
         if (short_word) begin
            err_short <= 1'b1;
         end

         // The MSB arrives on the WAIT_MSB cycle, one bclk after the lrck edge.
         case (state)
            UNSYNC: begin
               if (lr_edge) begin
                  state <= WAIT_MSB;
               end
            end
            WAIT_MSB: begin
               shreg    <= {{(DATA_W-1){1'b0}}, sdata};
               bit_cnt  <= CNT_W'(1);
               channel  <= lrck_d;
               slot_cnt <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               slot_cnt <= slot_cnt + 1'b1;
               if (commit) begin
                  state <= lr_edge ? WAIT_MSB : DONE;
               end else if (slot_cnt == SLOT_LAST) begin
                  state <= UNSYNC;
               end else begin
                  shreg   <= {shreg[DATA_W-2:0], sdata};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               if (lr_edge) begin
                  state <= WAIT_MSB;
               end else if (slot_cnt == SLOT_LAST) begin
                  state <= UNSYNC;
               end else begin
                  slot_cnt <= slot_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Directed bench for i2s_rx_slave: drives I2S half-frames on negedge bclk and
// checks held words, strobe slots and err_short against hand-computed values.
module tb_i2s_rx_slave;

   logic        bclk  = 1'b0;
   logic        rst   = 1'b0;
   logic        lrck  = 1'b0;
   logic        sdata = 1'b0;
   logic [15:0] l_data;
   logic [15:0] r_data;
   logic        l_valid;
   logic        r_valid;
   logic        pair_valid;
   logic        err_short;

   int compared   = 0;
   int mismatched = 0;
   int l_cnt, r_cnt, p_cnt, l_at, r_at, p_at;
   int both_total = 0;

   i2s_rx_slave #(.DATA_W(16), .SLOT_MAX(32)) dut (
      .bclk       (bclk),
      .rst        (rst),
      .lrck       (lrck),
      .sdata      (sdata),
      .l_data     (l_data),
      .r_data     (r_data),
      .l_valid    (l_valid),
      .r_valid    (r_valid),
      .pair_valid (pair_valid),
      .err_short  (err_short)
   );

   always #5 bclk = ~bclk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearCounts();
      l_cnt = 0; r_cnt = 0; p_cnt = 0;
      l_at = -1; r_at = -1; p_at = -1;
   endtask

   task automatic recordStrobes(input int k);
      if (l_valid)    begin l_cnt++; l_at = k; end
      if (r_valid)    begin r_cnt++; r_at = k; end
      if (pair_valid) begin p_cnt++; p_at = k; end
      if (l_valid && r_valid) both_total++;
   endtask

   // Slot 0 carries the lrck change, slots 1..nbits the word MSB first, the rest junk.
   task automatic applyStimulus(input logic ch, input logic [15:0] word, input int slots, input int nbits);
      for (int k = 0; k < slots; k++) begin
         @(negedge bclk);
         lrck = ch;
         if (k >= 1 && k <= nbits) sdata = word[16-k];
         else                      sdata = (k % 3 == 0);
         @(posedge bclk);
         #1;
         recordStrobes(k);
      end
   endtask

   initial begin
      $display("[TB] start");
      clearCounts();
      for (int i = 0; i < 6; i++) begin
         @(negedge bclk);
         sdata = ~sdata;
         @(posedge bclk);
         #1;
         recordStrobes(0);
      end
      checkOutput("rst_l_data", l_data, 16'h0000);
      checkOutput("rst_r_data", r_data, 16'h0000);
      checkOutput("rst_err", err_short, 1'b0);
      checkOutput("rst_strobes", l_cnt + r_cnt + p_cnt, 0);
      @(negedge bclk);
      rst = 1'b1;

      clearCounts();
      applyStimulus(1'b0, 16'hFFFF, 24, 16);
      checkOutput("unsync_strobes", l_cnt + r_cnt + p_cnt, 0);

      clearCounts();
      applyStimulus(1'b1, 16'h1234, 32, 16);
      checkOutput("first_r_cnt", r_cnt, 1);
      checkOutput("first_r_at", r_at, 17);
      checkOutput("first_r_data", r_data, 16'h1234);
      checkOutput("first_no_pair", p_cnt, 0);
      checkOutput("first_no_l", l_cnt, 0);

      clearCounts();
      applyStimulus(1'b0, 16'hA5C3, 32, 16);
      checkOutput("std_l_cnt", l_cnt, 1);
      checkOutput("std_l_at", l_at, 17);
      checkOutput("std_l_data", l_data, 16'hA5C3);
      checkOutput("std_l_no_r", r_cnt, 0);

      clearCounts();
      applyStimulus(1'b1, 16'h1234, 32, 16);
      checkOutput("std_r_at", r_at, 17);
      checkOutput("std_p_cnt", p_cnt, 1);
      checkOutput("std_p_at", p_at, 17);
      checkOutput("std_r_data", r_data, 16'h1234);
      checkOutput("std_l_held", l_data, 16'hA5C3);

      clearCounts();
      applyStimulus(1'b0, 16'h5A3C, 32, 16);
      applyStimulus(1'b1, 16'hEDCB, 32, 16);
      checkOutput("std2_l_data", l_data, 16'h5A3C);
      checkOutput("std2_r_data", r_data, 16'hEDCB);
      checkOutput("std2_p_cnt", p_cnt, 1);
      checkOutput("std2_err", err_short, 1'b0);

      clearCounts();
      applyStimulus(1'b0, 16'hFFFF, 11, 10);
      checkOutput("short_pending", l_cnt, 0);
      checkOutput("short_err_pre", err_short, 1'b0);
      clearCounts();
      applyStimulus(1'b1, 16'h0F0F, 32, 16);
      checkOutput("short_l_cnt", l_cnt, 1);
      checkOutput("short_l_at", l_at, 0);
      checkOutput("short_l_data", l_data, 16'hFFC0);
      checkOutput("short_err", err_short, 1'b1);
      checkOutput("short_r_data", r_data, 16'h0F0F);
      checkOutput("short_pair", p_cnt, 1);
      applyStimulus(1'b0, 16'hC3C3, 32, 16);
      applyStimulus(1'b1, 16'h3C3C, 32, 16);
      checkOutput("sticky_err", err_short, 1'b1);
      checkOutput("sticky_l_data", l_data, 16'hC3C3);
      checkOutput("sticky_r_data", r_data, 16'h3C3C);

      clearCounts();
      applyStimulus(1'b0, 16'h1111, 60, 16);
      checkOutput("lost_l_cnt", l_cnt, 1);
      checkOutput("lost_l_at", l_at, 17);
      checkOutput("lost_no_r", r_cnt + p_cnt, 0);
      clearCounts();
      applyStimulus(1'b1, 16'h2222, 32, 16);
      checkOutput("resume_r_at", r_at, 17);
      checkOutput("resume_r_data", r_data, 16'h2222);
      checkOutput("resume_pair", p_cnt, 1);

      applyStimulus(1'b0, 16'h3333, 32, 16);
      clearCounts();
      applyStimulus(1'b1, 16'hABCD, 9, 8);
      @(negedge bclk);
      rst   = 1'b0;
      sdata = 1'b1;
      @(posedge bclk);
      #1;
      recordStrobes(0);
      checkOutput("midrst_r_data", r_data, 16'h0000);
      checkOutput("midrst_l_data", l_data, 16'h0000);
      checkOutput("midrst_err", err_short, 1'b0);
      @(negedge bclk);
      rst = 1'b1;
      applyStimulus(1'b1, 16'hABCD, 20, 16);
      checkOutput("midrst_no_r", r_cnt, 0);
      checkOutput("midrst_r_held", r_data, 16'h0000);
      clearCounts();
      applyStimulus(1'b0, 16'h7FFF, 32, 16);
      applyStimulus(1'b1, 16'h8000, 32, 16);
      checkOutput("resync_l_data", l_data, 16'h7FFF);
      checkOutput("resync_r_data", r_data, 16'h8000);
      checkOutput("resync_l_cnt", l_cnt, 1);
      checkOutput("resync_r_cnt", r_cnt, 1);
      checkOutput("resync_pair", p_cnt, 1);
      checkOutput("never_both", both_total, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
